// File: rtl/pong_pkg.sv
// Shared constants and types for the Pong display path.
// Snapshot struct carries one coherent frame of game state.
package pong_pkg;
   localparam int NUM_LINHAS      = 8;
   localparam int NUM_COLUNAS     = 8;
   localparam int LINHA_RAQ_CIMA  = 0;
   localparam int LINHA_RAQ_BAIXO = 7;
   localparam logic [7:0] COL_OFF = 8'hFF;
   localparam logic [7:0] LIN_OFF = 8'h00;

   typedef struct packed {
      logic [2:0] linha_bola;
      logic [2:0] coluna_bola;
      logic [2:0] pos_cima;
      logic [2:0] pos_baixo;
      logic       ganhou;
      logic       perdeu;
      logic       pausado;
   } estado_jogo_t;

   function automatic logic [7:0] um_quente(input logic [2:0] i);
      return 8'b1 << i;
   endfunction

   // Paddle bits pos..pos+larg-1, clipped at column 7 (no wrap).
   function automatic logic [7:0] mascara_raq(input logic [2:0] pos, input int larg);
      logic [7:0] m;
      m = '0;
      for (int j = 0; j < NUM_COLUNAS; j++)
         m[j] = (j >= int'(pos)) && (j < int'(pos) + larg);
      return m;
   endfunction
endpackage

// File: rtl/varredura_matriz_padrao_linha.sv
// Combinational pixel pattern for one scanned row.
// Priority: win blink, then lose X blink, then paddles | ball.
module padrao_linha
   import pong_pkg::*;
#(
   parameter int LARG_RAQ = 2
) (
   input  logic [2:0]   linha,
   input  estado_jogo_t snap,
   input  logic         fase,
   output logic [7:0]   pix
);
   always_comb begin
      pix = '0;
      if (snap.ganhou) begin
         pix = fase ? 8'hFF : 8'h00;
      end else if (snap.perdeu) begin
         pix = fase ? (um_quente(linha) | um_quente(3'd7 - linha)) : 8'h00;
      end else begin
         if (linha == 3'(LINHA_RAQ_CIMA))
            pix = pix | mascara_raq(snap.pos_cima, LARG_RAQ);
         if (linha == 3'(LINHA_RAQ_BAIXO))
            pix = pix | mascara_raq(snap.pos_baixo, LARG_RAQ);
         // While paused the ball only shows in the lit half of the blink.
         if (linha == snap.linha_bola && !(snap.pausado && !fase))
            pix = pix | um_quente(snap.coluna_bola);
      end
   end
endmodule

// File: rtl/varredura_matriz.sv
// Row-multiplexed 8x8 LED scanner for the Pong game state.
// Latches a snapshot per frame, blanks each row's lead-in, drives blink phase.
module varredura_matriz
   import pong_pkg::*;
#(
   parameter int TICKS_POR_LINHA = 1000,
   parameter int BLANK_TICKS     = 8,
   parameter int BLINK_QUADROS   = 32,
   parameter int LARG_RAQ        = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] linha_bola,
   input  logic [2:0] coluna_bola,
   input  logic [2:0] posicao_raquete_cima,
   input  logic [2:0] posicao_raquete_baixo,
   input  logic       ganhou,
   input  logic       perdeu,
   input  logic       pausado,
   output logic [7:0] linhas,
   output logic [7:0] colunas,
   output logic       fim_quadro
);
   localparam int PW = $clog2(TICKS_POR_LINHA);
   localparam int FW = (BLINK_QUADROS > 1) ? $clog2(BLINK_QUADROS) : 1;

   logic [PW-1:0] p;
   logic [2:0]    r;
   logic [FW-1:0] f;
   logic          fase;
   estado_jogo_t  snap, entrada;
   logic [7:0]    pix;
   logic          fim_linha, fim_frame, inicio_frame;

   assign entrada = '{linha_bola: linha_bola, coluna_bola: coluna_bola,
                      pos_cima: posicao_raquete_cima, pos_baixo: posicao_raquete_baixo,
                      ganhou: ganhou, perdeu: perdeu, pausado: pausado};

   assign fim_linha    = (p == PW'(TICKS_POR_LINHA - 1));
   assign fim_frame    = fim_linha && (r == 3'd7);
   assign inicio_frame = (r == 3'd0) && (p == '0);

   padrao_linha #(.LARG_RAQ(LARG_RAQ)) u_padrao (
      .linha (r),
      .snap  (snap),
      .fase  (fase),
      .pix   (pix)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p          <= '0;
         r          <= '0;
         f          <= '0;
         fase       <= 1'b1;
         snap       <= '0;
         linhas     <= LIN_OFF;
         colunas    <= COL_OFF;
         fim_quadro <= 1'b0;
      end else begin
         p          <= fim_linha ? '0 : p + PW'(1);
         fim_quadro <= fim_frame;
         if (fim_linha)
            r <= r + 3'd1;
         if (fim_frame) begin
            if (f == FW'(BLINK_QUADROS - 1)) begin
               f    <= '0;
               fase <= ~fase;
            end else begin
               f <= f + FW'(1);
            end
         end
         if (inicio_frame)
            snap <= entrada;
         // Outputs lag the (r, p) state by one cycle.
         if (p < PW'(BLANK_TICKS)) begin
            linhas  <= LIN_OFF;
            colunas <= COL_OFF;
         end else begin
            linhas  <= um_quente(r);
            colunas <= ~pix;
         end
      end
   end
endmodule

// File: tb/tb_varredura_matriz.sv
// Directed bench for varredura_matriz with a 4-tick row, 1 blank tick, 2-frame blink.
module tb_varredura_matriz;
   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] linha_bola, coluna_bola, posicao_raquete_cima, posicao_raquete_baixo;
   logic       ganhou, perdeu, pausado;
   logic [7:0] linhas, colunas;
   logic       fim_quadro;

   int checks = 0;
   int errors = 0;
   int k = 0;
   logic [7:0] tab [8];

   varredura_matriz #(.TICKS_POR_LINHA(4), .BLANK_TICKS(1), .BLINK_QUADROS(2), .LARG_RAQ(2)) dut (
      .clk(clk), .reset(reset),
      .linha_bola(linha_bola), .coluna_bola(coluna_bola),
      .posicao_raquete_cima(posicao_raquete_cima), .posicao_raquete_baixo(posicao_raquete_baixo),
      .ganhou(ganhou), .perdeu(perdeu), .pausado(pausado),
      .linhas(linhas), .colunas(colunas), .fim_quadro(fim_quadro)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (k=%0d)", tag, obs, exp, k);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      k++;
   endtask

   // Advance to the sample where output shows frame n, row rr, tick pp (pp>=1 is lit).
   task automatic goto(input int n, input int rr, input int pp);
      int target;
      target = 32 * n + 4 * rr + pp + 1;
      checks++;
      if (target <= k) begin
         errors++;
         $error("FAIL goto target=%0d already passed k=%0d", target, k);
      end
      for (int i = 0; i < 2000 && k < target; i++) step();
   endtask

   task automatic chk_row(input string tag, input int rr, input logic [7:0] exp_c);
      chk({tag, "_lin"}, linhas, 8'b1 << rr);
      chk({tag, "_col"}, colunas, exp_c);
   endtask

   initial begin
      tab = '{8'hF3, 8'hFF, 8'hFF, 8'hDF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
      linha_bola = 3'd3; coluna_bola = 3'd5;
      posicao_raquete_cima = 3'd2; posicao_raquete_baixo = 3'd7;
      ganhou = 0; perdeu = 0; pausado = 0;
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      chk("rst_lin", linhas, 8'h00);
      chk("rst_col", colunas, 8'hFF);
      chk("rst_fim", {7'd0, fim_quadro}, 8'h00);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      k = 0;

      // Scan order, blanking, frame pulse and normal-play pattern.
      for (int i = 0; i < 40; i++) begin
         int ro, po;
         step();
         ro = ((k - 1) / 4) % 8;
         po = (k - 1) % 4;
         chk("scan_lin", linhas, (po == 0) ? 8'h00 : (8'b1 << ro));
         chk("scan_col", colunas, (po == 0) ? 8'hFF : tab[ro]);
         chk("scan_fim", {7'd0, fim_quadro}, {7'd0, (k % 32) == 0});
      end

      // Mid-frame ball move only shows from the next frame.
      goto(2, 2, 1);
      linha_bola = 3'd4;
      goto(2, 3, 1); chk_row("mid_f2_r3", 3, 8'hDF);
      goto(2, 4, 2); chk_row("mid_f2_r4", 4, 8'hFF);
      goto(3, 3, 1); chk_row("mid_f3_r3", 3, 8'hFF);
      goto(3, 4, 1); chk_row("mid_f3_r4", 4, 8'hDF);
      linha_bola = 3'd3;
      pausado = 1'b1;

      // Pause: ball blinks with a 2-frame half-period, paddles steady.
      goto(4, 3, 1); chk_row("pau_f4", 3, 8'hDF);
      goto(5, 3, 2); chk_row("pau_f5", 3, 8'hDF);
      goto(6, 0, 1); chk_row("pau_f6_r0", 0, 8'hF3);
      goto(6, 3, 1); chk_row("pau_f6", 3, 8'hFF);
      goto(6, 7, 3); chk_row("pau_f6_r7", 7, 8'h7F);
      goto(7, 3, 1); chk_row("pau_f7", 3, 8'hFF);
      goto(8, 3, 1); chk_row("pau_f8", 3, 8'hDF);
      pausado = 1'b0; ganhou = 1'b1; perdeu = 1'b1;

      // Win (overrides lose): whole matrix blinks.
      goto(9, 0, 1);  chk_row("win_f9", 0, 8'h00);
      goto(10, 3, 1); chk_row("win_f10", 3, 8'hFF);
      goto(11, 6, 3); chk_row("win_f11", 6, 8'hFF);
      goto(12, 1, 1); chk_row("win_f12", 1, 8'h00);
      goto(13, 7, 1); chk_row("win_f13", 7, 8'h00);
      ganhou = 1'b0;

      // Lose: X pattern blinks.
      goto(14, 1, 1); chk_row("lose_f14_r1", 1, 8'hFF);
      goto(16, 0, 1); chk_row("lose_f16_r0", 0, 8'h7E);
      goto(16, 1, 1); chk_row("lose_f16_r1", 1, 8'hBD);
      goto(16, 3, 2); chk_row("lose_f16_r3", 3, 8'hE7);
      goto(17, 5, 1); chk_row("lose_f17_r5", 5, 8'hDB);
      perdeu = 1'b0;

      // Mid-row reset at r=5, p=2.
      reset = 1'b0;
      #1;
      chk("mrst_lin", linhas, 8'h00);
      chk("mrst_col", colunas, 8'hFF);
      chk("mrst_fim", {7'd0, fim_quadro}, 8'h00);
      @(negedge clk);
      chk("mrst_hold_lin", linhas, 8'h00);
      reset = 1'b1;
      k = 0;
      step();
      chk("rel_blank_lin", linhas, 8'h00);
      chk("rel_blank_col", colunas, 8'hFF);
      step();
      chk_row("rel_r0", 0, 8'hF3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/varredura_matriz.md
Name: varredura_matriz

Overview:
- Display-side consumer of the Pong game-state interface: takes ball row/column, both paddle positions and the win/lose/pause flags, and renders them on a row-multiplexed 8x8 LED matrix.
- Sits after the game datapath at the board pins.
- Latches a coherent snapshot of the game state once per frame, so the picture never tears.
- Scans one row at a time with inter-row blanking, and generates blink effects for the pause, win and lose states.

Parameters:
- TICKS_POR_LINHA, 1000: clk cycles per scanned row. Legal range ≥2.
- BLANK_TICKS, 8: leading cycles of each row with all LEDs off (anti-ghosting). Legal range 1..TICKS_POR_LINHA-1.
- BLINK_QUADROS, 32: frames per blink half-period. Legal range ≥1.
- LARG_RAQ, 2: paddle width in columns.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- linha_bola  in  3  ball row, 0 = top.
- coluna_bola  in  3  ball column.
- posicao_raquete_cima  in  3  leftmost column of the top paddle (row 0).
- posicao_raquete_baixo  in  3  leftmost column of the bottom paddle (row 7).
- ganhou  in  1  win flag (level).
- perdeu  in  1  lose flag (level).
- pausado  in  1  game paused (level).
- linhas  out  8  row select, one-hot, active-high; bit i = row i.
- colunas  out  8  column drive, active-low; bit j = column j.
- fim_quadro  out  1  one-cycle pulse on each row-7 to row-0 wrap.

Behaviour:
- Reset (reset=0, async):
  - Prescaler p=0, row counter r=0, frame counter f=0, blink phase fase=1.
  - Snapshot registers = 0.
  - linhas=8'h00, colunas=8'hFF, fim_quadro=0.
- Prescaler p:
  - Counts 0..TICKS_POR_LINHA-1 every cycle and wraps to 0.
  - When p wraps, r increments; r wraps 7 to 0.
- Frame boundary (r=7 wrapping to 0):
  - fim_quadro=1 for exactly that one cycle (registered, coincident with r becoming 0).
  - f increments; when f wraps from BLINK_QUADROS-1 to 0, fase toggles.
- Snapshot:
  - On every edge where the current state is (r=0, p=0), all seven game inputs load into the snapshot registers. This includes the first cycle after reset release.
  - Input changes inside a frame are invisible until the next frame.
- Outputs are registered and reflect the (r, p) state of the previous cycle (1-cycle latency).
- Blanking:
  - If p < BLANK_TICKS: linhas=8'h00, colunas=8'hFF.
  - Otherwise: linhas = one-hot(r), colunas = ~pix(r).
- Pixel function pix(r), evaluated in this priority order (highest first):
  1. Snapshot ganhou=1: pix = 8'hFF when fase=1, else 8'h00 (whole matrix blinks).
  2. Else snapshot perdeu=1: pix = X pattern (bit r | bit 7-r) when fase=1, else 8'h00.
  3. Else normal play, OR of:
     - top paddle if r=0: bits pos..pos+LARG_RAQ-1, clipped at column 7 with no wrap (pos=7 gives 8'h80 only);
     - bottom paddle likewise if r=7;
     - ball bit coluna_bola if r=linha_bola; the ball is suppressed when pausado=1 and fase=0.
  - Ball on a paddle pixel: OR, so the pixel is simply lit.
- ganhou and perdeu both set: ganhou wins.
- Reset asserted mid-row forces the reset values immediately; the scan restarts at row 0 with a fresh snapshot.

Decomposition:
- Shared package pong_pkg holds:
  - NUM_LINHAS=8, NUM_COLUNAS=8;
  - LINHA_RAQ_CIMA=0, LINHA_RAQ_BAIXO=7;
  - COL_OFF=8'hFF, LIN_OFF=8'h00.
- One sub-module, padrao_linha: combinational function of (r, snapshot, fase) producing pix[7:0]. Counters, snapshot and output registers stay in varredura_matriz.

Test Plan (TICKS_POR_LINHA=4, BLANK_TICKS=1, BLINK_QUADROS=2):
- Reset release, then 40 cycles → linhas steps 01,02,04..80,01 every 4 cycles, and is 00 on the first cycle of each row. fim_quadro pulses once every 32 cycles, aligned with r returning to 0.
- Ball (3,5), paddles cima=2 / baixo=7, no flags:
  - row 0 colunas=8'hF3;
  - row 3 colunas=8'hDF;
  - row 7 colunas=8'h7F (clipped);
  - all other rows 8'hFF.
- Change linha_bola from 3 to 4 at mid-frame (r=2) → the current frame still shows the ball on row 3; the next frame shows it on row 4.
- pausado=1 with the ball at (3,5) → the ball pixel is present for 2 frames and absent for 2 frames, alternating; paddles stay steady.
- ganhou=1 and perdeu=1 → all rows colunas=8'h00 for 2 frames, then 8'hFF for 2 frames.
- perdeu=1 only → row 1 colunas=8'hBD.
- Assert reset at r=5, p=2 → linhas=00, colunas=FF, fim_quadro=0 immediately.
- Release reset → row 0 appears again after 1 blank cycle.
